fir_decim_serial: RTL

FIR_DECIM_SERIAL -- requirements
Module: fir_decim_serial

---
 rtl/fir_decim_serial.sv | 118 +++++++++++
 1 files changed

// File: rtl/fir_decim_serial.sv
// Serial decimating FIR: one multiply-accumulate per cycle over a circular sample buffer.
// Produces one output for every DECIM accepted samples, with a valid/ready handshake on both sides.
module fir_decim_serial #(
    parameter int TAPS  = 16,
    parameter int WIDTH = 16,
    parameter int DECIM = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [WIDTH-1:0]  din,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [WIDTH-1:0]  dout,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic signed [WIDTH-1:0]  coef_data
);

    localparam int AW    = $clog2(TAPS);
    localparam int PW    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int ACC_W = 2 * WIDTH + AW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]               state;
    logic signed [WIDTH-1:0]  samples [TAPS];
    logic signed [WIDTH-1:0]  coefs   [TAPS];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [AW-1:0]            tap;
    logic [PW-1:0]            phase;
    logic signed [ACC_W-1:0]  acc;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]  acc_sum;
    logic                     accept;
    logic                     coef_addr_ok;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(TAPS - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
        return (p == '0) ? AW'(TAPS - 1) : p - 1'b1;
    endfunction

    // Arithmetic shift right by WIDTH then keep WIDTH bits: plain truncation, overflow wraps.
    function automatic logic signed [WIDTH-1:0] trunc_out(input logic signed [ACC_W-1:0] a);
        return a[2*WIDTH-1:WIDTH];
    endfunction

    assign in_ready     = (state == S_IDLE);
    assign out_valid    = (state == S_OUT);
    assign accept       = in_valid && in_ready;
    assign coef_addr_ok = ({1'b0, coef_addr} < (AW + 1)'(TAPS));

    // The single multiplier: tap k pairs h[k] with x[n-k], walking the buffer backwards from the newest sample.
    assign prod    = coefs[tap] * samples[rd_ptr];
    assign acc_sum = acc + ACC_W'(prod);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            tap    <= '0;
            phase  <= '0;
            acc    <= '0;
            dout   <= '0;
            for (int i = 0; i < TAPS; i++) begin
                samples[i] <= '0;
                coefs[i]   <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (coef_we && coef_addr_ok) begin
                        coefs[coef_addr] <= coef_data;
                    end
                    if (accept) begin
                        samples[wr_ptr] <= din;
                        wr_ptr          <= ptr_inc(wr_ptr);
                        rd_ptr          <= wr_ptr;
                        tap             <= '0;
                        acc             <= '0;
                        if (phase == PW'(DECIM - 1)) begin
                            phase <= '0;
                            state <= S_MAC;
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    acc    <= acc_sum;
                    rd_ptr <= ptr_dec(rd_ptr);
                    if (tap == AW'(TAPS - 1)) begin
                        tap   <= '0;
                        dout  <= trunc_out(acc_sum);
                        state <= S_OUT;
                    end else begin
                        tap <= tap + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
